jcf_ctrl_unit: RTL and testbench

Parametrised, two-phase jump/condition/store control unit for the K2 datapath, sitting between the decoder and the PC/data-memory control. Owns the architectural flag register and a DECODE/EXEC phase state machine, so callers no longer supply an external phase bit. Supports selectable, optionally inverted condition flags and a one-cycle registered jump-taken pulse. Build-time option adds a hardware loop counter.

---
 rtl/jcf_ctrl_unit.sv | 152 +++++++++++++++
 tb/tb_jcf_ctrl_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jcf_ctrl_unit.sv
// jcf_ctrl_unit
// Two-phase jump/condition/store control for the K2 datapath. Owns the
// architectural flag register and a DECODE/EXEC phase FSM; every accepted
// instruction takes exactly two cycles. All outputs come from registered
// state only.
//
// Build option: define JCF_LOOP_EN to add a hardware loop counter that
// conditional jumps can test (loop_jmp) instead of a flag.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   instr_valid   instruction present (sampled in DECODE only)
//   op, d         opcode / destination field, latched on acceptance
//   cond_sel      flag index tested by a conditional jump
//   cond_inv      invert the tested condition
//   flags_in/we   flag register load
//   loop_load/val loop counter load (JCF_LOOP_EN only)
//   loop_jmp      conditional jump tests loop counter (JCF_LOOP_EN only)
//   jcf           jump taken, one-cycle pulse in EXEC
//   data_sel      store data path select in EXEC of a store
//   data_mem_en   data memory write enable (store with d == 2'b11)
//   busy          high in EXEC
//   flags_q       registered flags
//   loop_cnt      loop counter value (0 without JCF_LOOP_EN)
//
// state  | meaning
// DECODE | idle, waiting for instr_valid; outputs low
// EXEC   | instruction executing; outputs reflect latched op

module jcf_ctrl_unit #(
   parameter int FLAG_W = 4,
   parameter int SEL_W  = 2,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [1:0]        op,
   input  logic [SEL_W-1:0]  cond_sel,
   input  logic              cond_inv,
   input  logic [1:0]        d,
   input  logic [FLAG_W-1:0] flags_in,
   input  logic              flags_we,
   input  logic              loop_load,
   input  logic [CNT_W-1:0]  loop_val,
   input  logic              loop_jmp,
   output logic              jcf,
   output logic              data_sel,
   output logic              data_mem_en,
   output logic              busy,
   output logic [FLAG_W-1:0] flags_q,
   output logic [CNT_W-1:0]  loop_cnt
);

   localparam logic [0:0] S_DECODE = 1'b0;
   localparam logic [0:0] S_EXEC   = 1'b1;

   logic [0:0] state_q;
   logic [1:0] op_q;
   logic [1:0] d_q;
   logic       taken_q;
   logic       taken_c;
   logic       flag_bit;
   logic       loop_mode;
   logic       loop_nz;
   logic       accept;

   assign accept = (state_q == S_DECODE) && instr_valid;

   // Out-of-range selectors read as 0 when FLAG_W < 2**SEL_W.
   always_comb begin
      flag_bit = 1'b0;
      if (int'(cond_sel) < FLAG_W) flag_bit = flags_q[cond_sel];
   end

`ifdef JCF_LOOP_EN
   logic [CNT_W-1:0] loop_cnt_q;
   logic             loop_dec_q;

   assign loop_mode = (op == 2'b10) && loop_jmp;
   assign loop_nz   = (loop_cnt_q != '0);
   assign loop_cnt  = loop_cnt_q;

   // Decrement is deferred to the EXEC->DECODE edge so the count seen by
   // software during EXEC still matches the value that was tested.
   always_ff @(posedge clk) begin
      if (rst) begin
         loop_cnt_q <= '0;
         loop_dec_q <= 1'b0;
      end else begin
         if (accept) loop_dec_q <= loop_mode && loop_nz;
         if (loop_load)
            loop_cnt_q <= loop_val;
         else if ((state_q == S_EXEC) && loop_dec_q && loop_nz)
            loop_cnt_q <= loop_cnt_q - CNT_W'(1);
      end
   end
`else
   logic unused_loop;

   assign unused_loop = ^{loop_load, loop_val, loop_jmp};
   assign loop_mode   = 1'b0;
   assign loop_nz     = 1'b0;
   assign loop_cnt    = '0;
`endif

   always_comb begin
      taken_c = 1'b0;
      case (op)
         2'b01:   taken_c = 1'b1;
         2'b10:   taken_c = loop_mode ? loop_nz : (flag_bit ^ cond_inv);
         default: taken_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_DECODE;
         op_q    <= 2'b00;
         d_q     <= 2'b00;
         taken_q <= 1'b0;
      end else begin
         case (state_q)
            S_DECODE: begin
               if (instr_valid) begin
                  op_q    <= op;
                  d_q     <= d;
                  taken_q <= taken_c;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC:  state_q <= S_DECODE;
            default: state_q <= S_DECODE;
         endcase
      end
   end

   // Flags update in either phase; the condition above always sees the
   // pre-update value.
   always_ff @(posedge clk) begin
      if (rst)
         flags_q <= '0;
      else if (flags_we)
         flags_q <= flags_in;
   end

   assign busy        = (state_q == S_EXEC);
   assign jcf         = busy && taken_q;
   assign data_sel    = busy && (op_q == 2'b11);
   assign data_mem_en = data_sel && (d_q == 2'b11);

endmodule

// File: tb/tb_jcf_ctrl_unit.sv
module tb_jcf_ctrl_unit;
   localparam int FLAG_W = 4;
   localparam int SEL_W  = 2;
   localparam int CNT_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              instr_valid;
   logic [1:0]        op;
   logic [SEL_W-1:0]  cond_sel;
   logic              cond_inv;
   logic [1:0]        d;
   logic [FLAG_W-1:0] flags_in;
   logic              flags_we;
   logic              loop_load;
   logic [CNT_W-1:0]  loop_val;
   logic              loop_jmp;
   logic              jcf;
   logic              data_sel;
   logic              data_mem_en;
   logic              busy;
   logic [FLAG_W-1:0] flags_q;
   logic [CNT_W-1:0]  loop_cnt;

   always #5 clk = ~clk;

   jcf_ctrl_unit #(.FLAG_W(FLAG_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .op(op),
      .cond_sel(cond_sel), .cond_inv(cond_inv), .d(d), .flags_in(flags_in),
      .flags_we(flags_we), .loop_load(loop_load), .loop_val(loop_val),
      .loop_jmp(loop_jmp), .jcf(jcf), .data_sel(data_sel),
      .data_mem_en(data_mem_en), .busy(busy), .flags_q(flags_q),
      .loop_cnt(loop_cnt)
   );

   // {busy, jcf, data_sel, data_mem_en}
   typedef struct packed {
      logic busy;
      logic jcf;
      logic ds;
      logic dme;
   } outs_t;

   typedef struct {
      string      name;
      logic [3:0] flags;
      logic [1:0] op;
      logic [1:0] sel;
      logic       inv;
      logic [1:0] d;
      outs_t      exp;
   } vec_t;

   localparam outs_t IDLE   = 4'b0000;
   localparam outs_t EX_NT  = 4'b1000;
   localparam outs_t EX_TK  = 4'b1100;
   localparam outs_t EX_ST  = 4'b1010;
   localparam outs_t EX_STW = 4'b1011;

   outs_t exp_q[$];
   vec_t  vecs[12];
   int    vectors = 0;
   int    miscompares = 0;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_out(input outs_t e);
      exp_q.push_back(e);
   endtask

   task automatic step_check(input string name);
      outs_t a;
      outs_t e;
      step();
      a = {busy, jcf, data_sel, data_mem_en};
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: got %0h expected <scoreboard empty>", name, a);
      end else begin
         e = exp_q.pop_front();
         check_val(name, {28'b0, a}, {28'b0, e});
      end
   endtask

   task automatic idle_inputs();
      instr_valid = 1'b0; op = 2'b00; cond_sel = '0; cond_inv = 1'b0;
      d = 2'b00; flags_in = '0; flags_we = 1'b0; loop_load = 1'b0;
      loop_val = '0; loop_jmp = 1'b0;
   endtask

   initial begin
      int pulses;
      vecs[0]  = '{"zf_taken",     4'b0001, 2'b10, 2'd0, 1'b0, 2'b00, EX_TK};
      vecs[1]  = '{"zf_inv",       4'b0001, 2'b10, 2'd0, 1'b1, 2'b00, EX_NT};
      vecs[2]  = '{"cf_clear",     4'b0001, 2'b10, 2'd1, 1'b0, 2'b00, EX_NT};
      vecs[3]  = '{"jmp_uncond",   4'b0000, 2'b01, 2'd0, 1'b0, 2'b00, EX_TK};
      vecs[4]  = '{"store_d11",    4'b0000, 2'b11, 2'd0, 1'b0, 2'b11, EX_STW};
      vecs[5]  = '{"store_d10",    4'b0000, 2'b11, 2'd0, 1'b0, 2'b10, EX_ST};
      vecs[6]  = '{"alu_op",       4'b1111, 2'b00, 2'd0, 1'b0, 2'b11, EX_NT};
      vecs[7]  = '{"vf_taken",     4'b1000, 2'b10, 2'd3, 1'b0, 2'b00, EX_TK};
      vecs[8]  = '{"nf_inv",       4'b0100, 2'b10, 2'd2, 1'b1, 2'b00, EX_NT};
      vecs[9]  = '{"cf_taken",     4'b0010, 2'b10, 2'd1, 1'b0, 2'b00, EX_TK};
      vecs[10] = '{"zf0_inv",      4'b0000, 2'b10, 2'd0, 1'b1, 2'b00, EX_TK};
      vecs[11] = '{"jmp_d11",      4'b1111, 2'b01, 2'd0, 1'b0, 2'b11, EX_TK};

      idle_inputs();
      rst = 1'b1;
      step();
      expect_out(IDLE);
      step_check("reset_outs");
      check_val("reset_flags", {28'b0, flags_q}, 32'h0);
      check_val("reset_loop", {24'b0, loop_cnt}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         flags_in = vecs[i].flags;
         flags_we = 1'b1;
         expect_out(IDLE);
         step_check({vecs[i].name, "_fload"});
         flags_we = 1'b0;
         check_val({vecs[i].name, "_flags"}, {28'b0, flags_q}, {28'b0, vecs[i].flags});
         instr_valid = 1'b1;
         op = vecs[i].op; cond_sel = vecs[i].sel; cond_inv = vecs[i].inv; d = vecs[i].d;
         expect_out(vecs[i].exp);
         step_check(vecs[i].name);
         instr_valid = 1'b0;
         expect_out(IDLE);
         step_check({vecs[i].name, "_ret"});
      end
      idle_inputs();

      // flags_we coincident with acceptance is not seen by that instruction
      flags_in = 4'b0000; flags_we = 1'b1;
      expect_out(IDLE);
      step_check("coinc_clear");
      flags_in = 4'b0001; flags_we = 1'b1;
      instr_valid = 1'b1; op = 2'b10; cond_sel = 2'd0; cond_inv = 1'b0;
      expect_out(EX_NT);
      step_check("coinc_jcf");
      check_val("coinc_flags", {28'b0, flags_q}, 32'h1);
      idle_inputs();
      expect_out(IDLE);
      step_check("coinc_ret");

      // instr_valid held high: accepted every other cycle
      pulses = 0;
      instr_valid = 1'b1; op = 2'b01;
      for (int k = 0; k < 6; k++) begin
         expect_out((k % 2 == 0) ? EX_TK : IDLE);
         step_check("hold_valid");
         if (jcf === 1'b1) pulses++;
      end
      check_val("hold_pulses", 32'(pulses), 32'd3);
      idle_inputs();
      expect_out(IDLE);
      step_check("hold_ret");

      // reset for two cycles in EXEC of a taken jump
      flags_in = 4'b0101; flags_we = 1'b1;
      loop_load = 1'b1; loop_val = 8'd5;
      expect_out(IDLE);
      step_check("rst_setup");
      idle_inputs();
      instr_valid = 1'b1; op = 2'b01;
      expect_out(EX_TK);
      step_check("rst_pre");
      idle_inputs();
      rst = 1'b1; flags_we = 1'b1; flags_in = 4'b1111;
      expect_out(IDLE);
      step_check("rst_exec1");
      check_val("rst_flags", {28'b0, flags_q}, 32'h0);
      check_val("rst_loop", {24'b0, loop_cnt}, 32'h0);
      expect_out(IDLE);
      step_check("rst_exec2");
      rst = 1'b0; flags_we = 1'b0;
      instr_valid = 1'b1; op = 2'b11; d = 2'b11;
      expect_out(EX_STW);
      step_check("rst_after");
      idle_inputs();
      expect_out(IDLE);
      step_check("rst_after_ret");

`ifdef JCF_LOOP_EN
      begin
         int exp_cnt[3] = '{1, 0, 0};
         loop_load = 1'b1; loop_val = 8'd2;
         expect_out(IDLE);
         step_check("loop_load");
         loop_load = 1'b0;
         check_val("loop_cnt_init", {24'b0, loop_cnt}, 32'd2);
         for (int j = 0; j < 3; j++) begin
            // cond_inv=1 with ZF=0 would look taken if the flag path leaked in
            instr_valid = 1'b1; op = 2'b10; loop_jmp = 1'b1;
            cond_sel = 2'd0; cond_inv = 1'b1;
            expect_out((j < 2) ? EX_TK : EX_NT);
            step_check("loop_jmp");
            idle_inputs();
            expect_out(IDLE);
            step_check("loop_ret");
            check_val("loop_cnt", {24'b0, loop_cnt}, 32'(exp_cnt[j]));
         end
      end
`else
      loop_load = 1'b1; loop_val = 8'd7;
      expect_out(IDLE);
      step_check("noloop_load");
      loop_load = 1'b0;
      check_val("noloop_cnt", {24'b0, loop_cnt}, 32'h0);
      // loop_jmp must be ignored: ZF=0, cond_inv=0 -> not taken
      instr_valid = 1'b1; op = 2'b10; loop_jmp = 1'b1; cond_sel = 2'd0; cond_inv = 1'b0;
      expect_out(EX_NT);
      step_check("noloop_jmp");
      idle_inputs();
      expect_out(IDLE);
      step_check("noloop_ret");
`endif

      check_val("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
